// File: rtl/data_memory_sized_if.sv
// Request/response bundle for data_memory_sized: address, store data, load/store
// strobes, access size and extension in; load data, valid, misalign and busy out.
interface data_memory_sized_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] Address;
    logic [31:0]       WriteData;
    logic              MemoryRead;
    logic              MemoryWrite;
    logic [1:0]        AccessSize;
    logic              SignExtend;
    logic [31:0]       ReadData;
    logic              ReadValid;
    logic              Misaligned;
    logic              Busy;

    modport master (
        output Address, WriteData, MemoryRead, MemoryWrite,
        output AccessSize, SignExtend,
        input  ReadData, ReadValid, Misaligned, Busy
    );

    modport slave (
        input  Address, WriteData, MemoryRead, MemoryWrite,
        input  AccessSize, SignExtend,
        output ReadData, ReadValid, Misaligned, Busy
    );
endinterface

// File: rtl/data_memory_sized.sv
// Byte-addressed data memory: lb/lbu/lh/lhu/lw/sb/sh/sw, registered read port,
// misalignment pulse. Ports: Clock, Reset (sync, active high), bus (slave side).
// Optional MEM_CLEAR_ON_RESET_EN: zero the array one word per cycle after reset.
module data_memory_sized #(
    parameter int DEPTH      = 64,
    parameter bit BIG_ENDIAN = 1'b0,
    localparam int ADDR_W    = $clog2(DEPTH) + 2
) (
    input logic                Clock,
    input logic                Reset,
    data_memory_sized_if.slave bus
);
    localparam int IDX_W = ADDR_W - 2;

    logic [31:0] mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic [1:0]       phys_byte;
    logic             phys_half;
    logic             is_byte, is_half, is_word;
    logic             misal, busy, accept;
    logic             rd_req, wr_req, do_write;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic [31:0]      rd_word, rd_shift, load_val;
    logic [4:0]       sh_amt;

    logic [31:0] read_data_q, read_data_d;
    logic        read_valid_q, read_valid_d;
    logic        misaligned_q, misaligned_d;

    assign idx     = bus.Address[ADDR_W-1:2];
    assign lane    = bus.Address[1:0];
    assign is_byte = (bus.AccessSize == 2'b00);
    assign is_half = (bus.AccessSize == 2'b01);
    assign is_word = bus.AccessSize[1];

    // Position of the addressed byte/half inside the stored 32-bit word.
    assign phys_byte = BIG_ENDIAN ? ~lane : lane;
    assign phys_half = BIG_ENDIAN ? ~lane[1] : lane[1];

    assign misal    = (is_half & lane[0]) | (is_word & (|lane));
    assign accept   = ~Reset & ~busy;
    assign rd_req   = accept & bus.MemoryRead;
    assign wr_req   = accept & bus.MemoryWrite;
    assign do_write = wr_req & ~misal;

`ifdef MEM_CLEAR_ON_RESET_EN
    typedef enum logic {IDLE, CLEAR} state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             clr_we;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clr_we    = 1'b0;
        if (state_q == CLEAR) begin
            clr_we    = ~Reset;
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == LAST_IDX) begin
                state_d = IDLE;
            end
        end
    end

    assign busy = (state_q == CLEAR);
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        be    = 4'b0000;
        wdata = bus.WriteData;
        unique case (1'b1)
            is_byte: begin
                be[phys_byte] = 1'b1;
                wdata         = {4{bus.WriteData[7:0]}};
            end
            is_half: begin
                be    = phys_half ? 4'b1100 : 4'b0011;
                wdata = {2{bus.WriteData[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge Clock) begin
`ifdef MEM_CLEAR_ON_RESET_EN
        if (clr_we) begin
            mem[clr_idx_q] <= '0;
        end else
`endif
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Array read happens before the same-edge write lands: read-before-write.
    assign rd_word = mem[idx];

    always_comb begin
        sh_amt = 5'd0;
        if (is_byte) begin
            sh_amt = {phys_byte, 3'b000};
        end else if (is_half) begin
            sh_amt = {phys_half, 4'b0000};
        end
        rd_shift = rd_word >> sh_amt;
        load_val = rd_shift;
        if (is_byte) begin
            load_val = {{24{bus.SignExtend & rd_shift[7]}}, rd_shift[7:0]};
        end else if (is_half) begin
            load_val = {{16{bus.SignExtend & rd_shift[15]}}, rd_shift[15:0]};
        end
    end

    always_comb begin
        read_data_d  = read_data_q;
        read_valid_d = rd_req;
        misaligned_d = (rd_req | wr_req) & misal;
        if (rd_req) begin
            read_data_d = misal ? 32'h0 : load_val;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.ReadData   = read_data_q;
    assign bus.ReadValid  = read_valid_q;
    assign bus.Misaligned = misaligned_q;
    assign bus.Busy       = busy;
endmodule

// File: tb/tb_data_memory_sized.sv
// Self-checking bench for data_memory_sized: little- and big-endian instances
// driven in lockstep and compared against a byte-array reference model.
module tb_data_memory_sized;
    localparam int DEPTH = 64;
    localparam int AW    = 8;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    data_memory_sized_if #(.ADDR_W(AW)) bus_le ();
    data_memory_sized_if #(.ADDR_W(AW)) bus_be ();

    data_memory_sized #(.DEPTH(DEPTH), .BIG_ENDIAN(1'b0)) dut_le (
        .Clock(Clock), .Reset(Reset), .bus(bus_le)
    );
    data_memory_sized #(.DEPTH(DEPTH), .BIG_ENDIAN(1'b1)) dut_be (
        .Clock(Clock), .Reset(Reset), .bus(bus_be)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one byte array per endianness, indexed by byte address.
    logic [7:0]  mb [2][256];
    logic [31:0] exp_rd [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic is_misal(input logic [7:0] a, input logic [1:0] sz);
        if (sz == 2'b01) return a[0];
        if (sz[1]) return (a[1:0] != 2'b00);
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_ld(input int e, input logic [7:0] a,
                                             input logic [1:0] sz, input logic sx);
        logic [7:0]  b0, b1, b2, b3;
        logic [15:0] h;
        b0 = mb[e][a];
        b1 = mb[e][8'(a + 8'd1)];
        b2 = mb[e][8'(a + 8'd2)];
        b3 = mb[e][8'(a + 8'd3)];
        if (sz == 2'b00) return sx ? {{24{b0[7]}}, b0} : {24'h0, b0};
        if (sz == 2'b01) begin
            h = (e == 1) ? {b0, b1} : {b1, b0};
            return sx ? {{16{h[15]}}, h} : {16'h0, h};
        end
        return (e == 1) ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
    endfunction

    task automatic model_st(input int e, input logic [7:0] a,
                            input logic [31:0] wd, input logic [1:0] sz);
        int n;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            // i-th byte in address order takes the i-th most/least significant byte
            mb[e][8'(a + 8'(i))] = (e == 1) ? wd[8*(n-1-i) +: 8] : wd[8*i +: 8];
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [7:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic sx);
        bus_le.MemoryRead = rd;  bus_be.MemoryRead = rd;
        bus_le.MemoryWrite = wr; bus_be.MemoryWrite = wr;
        bus_le.Address = a;      bus_be.Address = a;
        bus_le.WriteData = wd;   bus_be.WriteData = wd;
        bus_le.AccessSize = sz;  bus_be.AccessSize = sz;
        bus_le.SignExtend = sx;  bus_be.SignExtend = sx;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 2'b10, 1'b0);
    endtask

    task automatic check_outs(input string tag, input logic rv, input logic mis);
        chk({tag, "_rd_le"}, bus_le.ReadData, exp_rd[0]);
        chk({tag, "_rd_be"}, bus_be.ReadData, exp_rd[1]);
        chk({tag, "_rv_le"}, 32'(bus_le.ReadValid), 32'(rv));
        chk({tag, "_rv_be"}, 32'(bus_be.ReadValid), 32'(rv));
        chk({tag, "_mis_le"}, 32'(bus_le.Misaligned), 32'(mis));
        chk({tag, "_mis_be"}, 32'(bus_be.Misaligned), 32'(mis));
        chk({tag, "_busy"}, 32'({bus_le.Busy, bus_be.Busy}), 32'h0);
    endtask

    // One accepted request: expected load data comes from the model before the store.
    task automatic req(input string tag, input logic rd, input logic wr, input logic [7:0] a,
                       input logic [31:0] wd, input logic [1:0] sz, input logic sx);
        logic mis;
        mis = is_misal(a, sz);
        for (int e = 0; e < 2; e++) begin
            if (rd) exp_rd[e] = mis ? 32'h0 : model_ld(e, a, sz, sx);
        end
        drive(rd, wr, a, wd, sz, sx);
        @(posedge Clock);
        #1;
        idle();
        if (wr && !mis) begin
            for (int e = 0; e < 2; e++) model_st(e, a, wd, sz);
        end
        check_outs(tag, rd, (rd | wr) & mis);
    endtask

    task automatic do_reset(input string tag);
        int n0, n1;
        Reset = 1'b1;
        idle();
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        chk({tag, "_rst_rd"}, bus_le.ReadData | bus_be.ReadData, 32'h0);
        chk({tag, "_rst_rv"}, 32'({bus_le.ReadValid, bus_be.ReadValid}), 32'h0);
        chk({tag, "_rst_mis"}, 32'({bus_le.Misaligned, bus_be.Misaligned}), 32'h0);
`ifdef MEM_CLEAR_ON_RESET_EN
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 200; c++) begin
            if (!bus_le.Busy && !bus_be.Busy) break;
            if (bus_le.Busy) n0++;
            if (bus_be.Busy) n1++;
            @(posedge Clock);
            #1;
        end
        chk({tag, "_busy_cyc_le"}, 32'(n0), 32'(DEPTH));
        chk({tag, "_busy_cyc_be"}, 32'(n1), 32'(DEPTH));
        for (int e = 0; e < 2; e++)
            for (int i = 0; i < 256; i++) mb[e][i] = 8'h00;
`else
        n0 = 0;
        n1 = 0;
        chk({tag, "_busy0"}, 32'({bus_le.Busy, bus_be.Busy}), 32'(n0 + n1));
`endif
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            req(tag, 1'b1, 1'b0, 8'(4 * i), 32'h0, 2'b10, 1'b0);
        end
    endtask

    initial begin
        logic [31:0] old_lo;
        idle();
        for (int e = 0; e < 2; e++)
            for (int i = 0; i < 256; i++) mb[e][i] = 8'h00;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        @(posedge Clock);
        #1;
        do_reset("init");

        for (int i = 0; i < DEPTH; i++) begin
            req("fill", 1'b0, 1'b1, 8'(4 * i), $urandom, 2'b10, 1'b0);
        end

        req("t1_sw", 1'b0, 1'b1, 8'h08, 32'h11223344, 2'b10, 1'b0);
        req("t1_lw", 1'b1, 1'b0, 8'h08, 32'h0, 2'b10, 1'b0);
        chk("t1_const", bus_le.ReadData, 32'h11223344);
        chk("t1_const_be", bus_be.ReadData, 32'h11223344);

        req("t2_lb", 1'b1, 1'b0, 8'h0B, 32'h0, 2'b00, 1'b0);
        chk("t2_lb_const", bus_le.ReadData, 32'h00000011);
        chk("t2_lb_const_be", bus_be.ReadData, 32'h00000044);
        req("t2_sb", 1'b0, 1'b1, 8'h09, 32'h000000AA, 2'b00, 1'b0);
        req("t2_lw", 1'b1, 1'b0, 8'h08, 32'h0, 2'b10, 1'b0);
        chk("t2_lw_const", bus_le.ReadData, 32'h1122AA44);
        chk("t2_lw_const_be", bus_be.ReadData, 32'h11AA3344);

        old_lo = model_ld(0, 8'h10, 2'b01, 1'b0);
        req("t3_sh", 1'b0, 1'b1, 8'h12, 32'h00008001, 2'b01, 1'b0);
        req("t3_lh", 1'b1, 1'b0, 8'h12, 32'h0, 2'b01, 1'b1);
        chk("t3_lh_const", bus_le.ReadData, 32'hFFFF8001);
        req("t3_lhu", 1'b1, 1'b0, 8'h12, 32'h0, 2'b01, 1'b0);
        chk("t3_lhu_const", bus_le.ReadData, 32'h00008001);
        req("t3_lw", 1'b1, 1'b0, 8'h10, 32'h0, 2'b10, 1'b0);
        chk("t3_lw_const", bus_le.ReadData, {16'h8001, old_lo[15:0]});

        req("t4_sw_mis", 1'b0, 1'b1, 8'h06, 32'hDEADBEEF, 2'b10, 1'b0);
        req("t4_lh_mis", 1'b1, 1'b0, 8'h03, 32'h0, 2'b01, 1'b1);
        req("t4_lw", 1'b1, 1'b0, 8'h04, 32'h0, 2'b10, 1'b0);
        req("t4_rw_mis", 1'b1, 1'b1, 8'h0D, 32'h12345678, 2'b11, 1'b0);

        req("t5_sw", 1'b0, 1'b1, 8'h20, 32'd5, 2'b10, 1'b0);
        req("t5_rw", 1'b1, 1'b1, 8'h20, 32'd9, 2'b10, 1'b0);
        chk("t5_old", bus_le.ReadData, 32'd5);
        req("t5_lw", 1'b1, 1'b0, 8'h20, 32'h0, 2'b10, 1'b0);
        chk("t5_new", bus_le.ReadData, 32'd9);

        @(posedge Clock);
        #1;
        check_outs("hold", 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(posedge Clock);
                #1;
                check_outs("rnd_idle", 1'b0, 1'b0);
            end else begin
                req("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom), $urandom, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
            end
        end

        do_reset("rst2");
        read_all("after_rst2");

`ifdef MEM_CLEAR_ON_RESET_EN
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        for (int c = 0; c < 29; c++) begin
            @(posedge Clock);
            #1;
        end
        drive(1'b1, 1'b1, 8'h08, 32'hCAFEF00D, 2'b10, 1'b0);
        @(posedge Clock);
        #1;
        idle();
        chk("busy_drop_rv", 32'({bus_le.ReadValid, bus_be.ReadValid}), 32'h0);
        chk("busy_drop_mis", 32'({bus_le.Misaligned, bus_be.Misaligned}), 32'h0);
        chk("busy_mid", 32'({bus_le.Busy, bus_be.Busy}), 32'h3);
        do_reset("restart");
        read_all("cleared");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
